food_spawner: RTL

- Multi-slot food ("egg") manager for the snake playfield; successor to the single-egg refresher.
- Keeps up to NUM_FOOD food cells alive and detects when the snake head eats one.
- Respawns eaten food at LFSR-random cells, rejecting cells occupied by the snake body (via a query handshake to the body tracker), by the head, or by other food.
- Produces a registered per-pixel food flag for the VGA renderer.

---
 rtl/food_spawner.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/food_spawner.sv
// Multi-slot food manager: detects eaten food, respawns it at random free
// cells via an LFSR and a body-occupancy query, and renders a food pixel flag.
module food_spawner #(
    parameter int unsigned FIELD_W    = 34,
    parameter int unsigned FIELD_H    = 26,
    parameter int unsigned X_OFS      = 1,
    parameter int unsigned Y_OFS      = 1,
    parameter int unsigned NUM_FOOD   = 4,
    parameter int unsigned COORD_W    = 6,
    parameter int unsigned CELL_SHIFT = 4,
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned V_ACTIVE   = 480,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter int unsigned MAX_TRIES  = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         head_valid,
    input  logic [COORD_W-1:0]           head_x,
    input  logic [COORD_W-1:0]           head_y,
    output logic                         occ_req,
    output logic [COORD_W-1:0]           occ_x,
    output logic [COORD_W-1:0]           occ_y,
    input  logic                         occ_ack,
    input  logic                         occ_hit,
    output logic [NUM_FOOD*COORD_W-1:0]  food_x,
    output logic [NUM_FOOD*COORD_W-1:0]  food_y,
    output logic [NUM_FOOD-1:0]          food_valid,
    output logic                         eat,
    output logic [2:0]                   eat_idx,
    output logic                         spawn_fail,
    input  logic [9:0]                   pix_x,
    input  logic [9:0]                   pix_y,
    output logic                         food_pix
);

    localparam int unsigned SLOT_W = (NUM_FOOD > 1) ? $clog2(NUM_FOOD) : 1;
    localparam int unsigned TRY_W  = $clog2(MAX_TRIES + 1);
    localparam int unsigned PIX_W  = 10;

    typedef enum logic [2:0] {S_IDLE, S_PICK, S_CHECK, S_QUERY, S_COMMIT} state_t;

    state_t                       state_q;
    logic [15:0]                  lfsr_q, lfsr_d;
    logic [SLOT_W-1:0]            slot_q;
    logic [TRY_W-1:0]             try_q;
    logic [COORD_W-1:0]           cand_x_q, cand_y_q;
    logic                         occ_req_q;
    logic [COORD_W-1:0]           occ_x_q, occ_y_q;
    logic [NUM_FOOD*COORD_W-1:0]  food_x_q, food_y_q;
    logic [NUM_FOOD-1:0]          food_valid_q;
    logic                         eat_q, spawn_fail_q, food_pix_q;
    logic [2:0]                   eat_idx_q;

    logic [COORD_W-1:0]           cand_x_raw_c, cand_y_raw_c;
    logic                         cand_ok_c;
    logic                         eat_hit_c, free_any_c, clash_c, pix_hit_c, pix_in_c;
    logic [SLOT_W-1:0]            eat_sel_c, free_idx_c;
    logic [PIX_W-1:0]             pix_cx_c, pix_cy_c;

    // Galois LFSR step, taps x^16+x^14+x^13+x^11+1
    assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

    assign cand_x_raw_c = lfsr_q[COORD_W-1:0];
    assign cand_y_raw_c = lfsr_q[2*COORD_W-1:COORD_W];
    assign cand_ok_c    = (cand_x_raw_c < COORD_W'(FIELD_W)) && (cand_y_raw_c < COORD_W'(FIELD_H));

    assign pix_cx_c = pix_x >> CELL_SHIFT;
    assign pix_cy_c = pix_y >> CELL_SHIFT;
    assign pix_in_c = (pix_x < PIX_W'(H_ACTIVE)) && (pix_y < PIX_W'(V_ACTIVE));

    // Slot scan: lowest eaten slot, lowest free slot, candidate clash, pixel hit
    always_comb begin
        eat_hit_c  = 1'b0;
        eat_sel_c  = '0;
        free_any_c = 1'b0;
        free_idx_c = '0;
        clash_c    = (cand_x_q == head_x) && (cand_y_q == head_y);
        pix_hit_c  = 1'b0;
        for (int i = 0; i < NUM_FOOD; i++) begin
            if (!eat_hit_c && enable && head_valid && food_valid_q[i] &&
                head_x == food_x_q[i*COORD_W +: COORD_W] &&
                head_y == food_y_q[i*COORD_W +: COORD_W]) begin
                eat_hit_c = 1'b1;
                eat_sel_c = SLOT_W'(i);
            end
            if (!free_any_c && !food_valid_q[i]) begin
                free_any_c = 1'b1;
                free_idx_c = SLOT_W'(i);
            end
            if (food_valid_q[i] && SLOT_W'(i) != slot_q &&
                cand_x_q == food_x_q[i*COORD_W +: COORD_W] &&
                cand_y_q == food_y_q[i*COORD_W +: COORD_W]) begin
                clash_c = 1'b1;
            end
            if (food_valid_q[i] &&
                pix_cx_c == PIX_W'(food_x_q[i*COORD_W +: COORD_W]) &&
                pix_cy_c == PIX_W'(food_y_q[i*COORD_W +: COORD_W])) begin
                pix_hit_c = 1'b1;
            end
        end
    end

    // LFSR free-runs and the render flag is a one-cycle registered lookup
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q     <= LFSR_SEED;
            food_pix_q <= 1'b0;
        end else begin
            lfsr_q     <= lfsr_d;
            food_pix_q <= pix_in_c && pix_hit_c;
        end
    end

    // Eat detection and spawn FSM sharing the slot registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            slot_q       <= '0;
            try_q        <= '0;
            cand_x_q     <= '0;
            cand_y_q     <= '0;
            occ_req_q    <= 1'b0;
            occ_x_q      <= '0;
            occ_y_q      <= '0;
            food_x_q     <= '0;
            food_y_q     <= '0;
            food_valid_q <= '0;
            eat_q        <= 1'b0;
            eat_idx_q    <= '0;
            spawn_fail_q <= 1'b0;
        end else begin
            eat_q        <= 1'b0;
            spawn_fail_q <= 1'b0;
            if (eat_hit_c) begin
                eat_q                   <= 1'b1;
                eat_idx_q               <= 3'(eat_sel_c);
                food_valid_q[eat_sel_c] <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (enable && free_any_c) begin
                        slot_q  <= free_idx_c;
                        try_q   <= '0;
                        state_q <= S_PICK;
                    end
                end
                S_PICK: begin
                    if (!enable) begin
                        state_q <= S_IDLE;
                    end else if (try_q >= TRY_W'(MAX_TRIES)) begin
                        spawn_fail_q <= 1'b1;
                        state_q      <= S_IDLE;
                    end else if (cand_ok_c) begin
                        cand_x_q <= cand_x_raw_c + COORD_W'(X_OFS);
                        cand_y_q <= cand_y_raw_c + COORD_W'(Y_OFS);
                        state_q  <= S_CHECK;
                    end else begin
                        try_q <= try_q + TRY_W'(1);
                    end
                end
                S_CHECK: begin
                    if (!enable) begin
                        state_q <= S_IDLE;
                    end else if (clash_c) begin
                        try_q   <= try_q + TRY_W'(1);
                        state_q <= S_PICK;
                    end else begin
                        occ_req_q <= 1'b1;
                        occ_x_q   <= cand_x_q;
                        occ_y_q   <= cand_y_q;
                        state_q   <= S_QUERY;
                    end
                end
                S_QUERY: begin
                    if (occ_ack) begin
                        occ_req_q <= 1'b0;
                        if (!enable) begin
                            state_q <= S_IDLE;
                        end else if (occ_hit) begin
                            try_q   <= try_q + TRY_W'(1);
                            state_q <= S_PICK;
                        end else begin
                            state_q <= S_COMMIT;
                        end
                    end
                end
                S_COMMIT: begin
                    if (enable) begin
                        food_x_q[slot_q*COORD_W +: COORD_W] <= cand_x_q;
                        food_y_q[slot_q*COORD_W +: COORD_W] <= cand_y_q;
                        food_valid_q[slot_q]                <= 1'b1;
                    end
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign occ_req    = occ_req_q;
    assign occ_x      = occ_x_q;
    assign occ_y      = occ_y_q;
    assign food_x     = food_x_q;
    assign food_y     = food_y_q;
    assign food_valid = food_valid_q;
    assign eat        = eat_q;
    assign eat_idx    = eat_idx_q;
    assign spawn_fail = spawn_fail_q;
    assign food_pix   = food_pix_q;

endmodule
